// File: rtl/sign_mag_alu_pipe_if.sv
// Handshake/data bundle for the sign-magnitude add/sub/accumulate pipe.
// master = producer/consumer side (bench), slave = the pipe itself.
interface sign_mag_alu_pipe_if #(
  parameter int N = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         ovf;
  logic [N-1:0] acc;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, sum, ovf, acc
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, sum, ovf, acc
  );
endinterface

// File: rtl/sign_mag_alu_pipe.sv
// Two-stage sign-magnitude ADD/SUB/ACC/CLR unit with valid/ready on both
// sides. S1 holds the normalised request, S2 holds the result. The
// arithmetic sits between S1 and S2 so ACC always reads the accumulator as
// left by every older operation (it retires into S2 on the same edge).
module sign_mag_alu_pipe #(
  parameter int N   = 4,
  parameter bit SAT = 1'b0
) (
  input logic             clk,
  input logic             rst,
  sign_mag_alu_pipe_if.slave bus
);
  localparam int M = N - 1;  // magnitude width

  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_ACC = 2'b10, OP_CLR = 2'b11} op_e;

  typedef struct packed {
    op_e          op;
    logic [N-1:0] a;
    logic [N-1:0] b;
  } req_t;

  // Map -0 to +0 so the datapath never sees a signed zero.
  function automatic logic [N-1:0] norm(input logic [N-1:0] v);
    return (v[M-1:0] == '0) ? '0 : v;
  endfunction

  req_t         s1_req;
  logic         s1_valid;
  logic         out_valid;
  logic [N-1:0] sum_q;
  logic         ovf_q;
  logic [N-1:0] acc_q;

  logic         accept;
  logic         advance;
  req_t         cap_req;

  logic         xs, ys;
  logic [M-1:0] xm, ym;
  logic [N-1:0] msum;
  logic [M-1:0] mag;
  logic         sgn;
  logic         res_ovf;
  logic [N-1:0] res;

  assign advance      = s1_valid && (!out_valid || bus.out_ready);
  assign bus.in_ready = !rst && (!s1_valid || !out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.out_valid = out_valid;
  assign bus.sum       = sum_q;
  assign bus.ovf       = ovf_q;
  assign bus.acc       = acc_q;

  // Capture-side normalisation; SUB becomes ADD with b's sign flipped
  // (a zero b stays +0).
  always_comb begin
    cap_req.op = op_e'(bus.op);
    cap_req.a  = norm(bus.a);
    cap_req.b  = norm(bus.b);
    if (cap_req.op == OP_SUB && cap_req.b[M-1:0] != '0)
      cap_req.b[N-1] = ~cap_req.b[N-1];
  end

  // Sign-magnitude add of X and Y; ACC uses (acc, a), ADD/SUB use (a, b).
  always_comb begin
    xs      = (s1_req.op == OP_ACC) ? acc_q[N-1]   : s1_req.a[N-1];
    xm      = (s1_req.op == OP_ACC) ? acc_q[M-1:0] : s1_req.a[M-1:0];
    ys      = (s1_req.op == OP_ACC) ? s1_req.a[N-1]   : s1_req.b[N-1];
    ym      = (s1_req.op == OP_ACC) ? s1_req.a[M-1:0] : s1_req.b[M-1:0];
    msum    = '0;
    mag     = '0;
    sgn     = 1'b0;
    res_ovf = 1'b0;
    if (s1_req.op == OP_CLR) begin
      mag = '0;
      sgn = 1'b0;
    end else if (xs == ys) begin
      msum    = {1'b0, xm} + {1'b0, ym};
      res_ovf = msum[N-1];
      mag     = (res_ovf && SAT) ? {M{1'b1}} : msum[M-1:0];
      sgn     = xs;
    end else if (xm >= ym) begin
      mag = xm - ym;
      sgn = xs;
    end else begin
      mag = ym - xm;
      sgn = ys;
    end
    // A zero result is always +0.
    res = {sgn && (mag != '0), mag};
  end

  // Stage 1: refill on accept, empty when the entry advances without refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_req   <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_req   <= cap_req;
    end else if (advance) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2 and accumulator: load on advance, drop valid once consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum_q     <= '0;
      ovf_q     <= 1'b0;
      acc_q     <= '0;
    end else if (advance) begin
      out_valid <= 1'b1;
      sum_q     <= res;
      ovf_q     <= res_ovf;
      if (s1_req.op == OP_ACC || s1_req.op == OP_CLR)
        acc_q <= res;
    end else if (bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sign_mag_alu_pipe.sv
// Directed bench for sign_mag_alu_pipe: two instances (wrap and saturate)
// share one stimulus stream; results are checked in order from a queue.
module tb_sign_mag_alu_pipe;
  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ACC = 2'b10, CLR = 2'b11;

  logic clk;
  logic rst;

  sign_mag_alu_pipe_if #(.N(4)) bus0 ();
  sign_mag_alu_pipe_if #(.N(4)) bus1 ();

  sign_mag_alu_pipe #(.N(4), .SAT(1'b0)) dut_wrap (.clk(clk), .rst(rst), .bus(bus0.slave));
  sign_mag_alu_pipe #(.N(4), .SAT(1'b1)) dut_sat  (.clk(clk), .rst(rst), .bus(bus1.slave));

  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.op        = bus0.op;
  assign bus1.a         = bus0.a;
  assign bus1.b         = bus0.b;
  assign bus1.out_ready = bus0.out_ready;

  typedef struct packed {
    logic [3:0] s0;
    logic       o0;
    logic [3:0] s1;
    logic       o1;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   n_acc = 0;
  int   cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [3:0] s0, input logic o0, input logic [3:0] s1, input logic o1);
    exp_t e;
    e.s0 = s0; e.o0 = o0; e.s1 = s1; e.o1 = o1;
    q.push_back(e);
  endtask

  // Integer-domain reference: returns {ovf, sign, mag[2:0]}.
  function automatic logic [4:0] ref_model(input logic [1:0] o, input logic [3:0] av,
                                           input logic [3:0] bv, input bit sat);
    int x, y, r, m;
    logic s;
    x = av[3] ? -int'(av[2:0]) : int'(av[2:0]);
    y = bv[3] ? -int'(bv[2:0]) : int'(bv[2:0]);
    if (o == SUB) y = -y;
    r = x + y;
    m = (r < 0) ? -r : r;
    ref_model[4] = (m > 7);
    if (m > 7) m = sat ? 7 : m - 8;
    s = (r < 0) && (m != 0);
    ref_model[3:0] = {s, 3'(m)};
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [1:0] o, input logic [3:0] av, input logic [3:0] bv);
    bit ok;
    ok = 1'b0;
    bus0.in_valid = 1'b1;
    bus0.op = o;
    bus0.a  = av;
    bus0.b  = bv;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = bus0.in_ready;
      @(posedge clk);
      #1;
    end
    bus0.in_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (q.size() == 0 && !bus0.out_valid) break;
    end
    chk("drain_left", q.size(), 0);
  endtask

  // Output monitor: a transfer happens on the next edge when both are high.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus0.in_valid && bus0.in_ready) n_acc++;
      if (bus0.out_valid && bus0.out_ready) begin
        chk("sat_valid", bus1.out_valid, 1);
        if (q.size() == 0) begin
          chk("extra_out", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sum", bus0.sum, e.s0);
          chk("ovf", bus0.ovf, e.o0);
          chk("sum_sat", bus1.sum, e.s1);
          chk("ovf_sat", bus1.ovf, e.o1);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    logic [4:0] m0, m1;
    rst = 1'b1;
    bus0.in_valid = 1'b0;
    bus0.op = ADD;
    bus0.a = '0;
    bus0.b = '0;
    bus0.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus0.out_valid, 0);
    chk("rst_sum", bus0.sum, 0);
    chk("rst_ovf", bus0.ovf, 0);
    chk("rst_acc", bus0.acc, 0);
    chk("rst_in_ready", bus0.in_ready, 0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", bus0.in_ready, 1);

    // Basic ADD with latency check: +3 + -5 = -2.
    push_exp(4'b1010, 0, 4'b1010, 0);
    send(ADD, 4'b0011, 4'b1101);
    chk("lat_edge1_valid", bus0.out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_edge2_valid", bus0.out_valid, 1);
    chk("lat_sum", bus0.sum, 4'b1010);
    // Overflow: +7 + +1 wraps to +0, saturates to +7.
    push_exp(4'b0000, 1, 4'b0111, 1);
    send(ADD, 4'b0111, 4'b0001);
    drain();

    // Zero normalisation and SUB.
    push_exp(4'b0000, 0, 4'b0000, 0);
    send(ADD, 4'b1011, 4'b0011);
    push_exp(4'b0000, 0, 4'b0000, 0);
    send(ADD, 4'b1000, 4'b1000);
    push_exp(4'b0110, 0, 4'b0110, 0);
    send(SUB, 4'b0010, 4'b1100);
    push_exp(4'b0000, 0, 4'b0000, 0);
    send(SUB, 4'b0010, 4'b0010);
    drain();

    // Accumulator chain, back-to-back: 0, +5, +5 + -7 = -2.
    push_exp(4'b0000, 0, 4'b0000, 0);
    send(CLR, 4'b0000, 4'b0000);
    push_exp(4'b0101, 0, 4'b0101, 0);
    send(ACC, 4'b0101, 4'b0000);
    push_exp(4'b1010, 0, 4'b1010, 0);
    send(ACC, 4'b1111, 4'b0000);
    drain();
    chk("acc_chain", bus0.acc, 4'b1010);
    chk("acc_chain_sat", bus1.acc, 4'b1010);

    // Backpressure: 6 ADDs, out_ready low for 4 cycles.
    push_exp(4'b0011, 0, 4'b0011, 0);
    push_exp(4'b0111, 0, 4'b0111, 0);
    push_exp(4'b1011, 0, 4'b1011, 0);
    push_exp(4'b0100, 0, 4'b0100, 0);
    push_exp(4'b0000, 0, 4'b0000, 0);
    push_exp(4'b0010, 1, 4'b0111, 1);
    n_acc = 0;
    bus0.out_ready = 1'b0;
    fork
      begin
        send(ADD, 4'b0001, 4'b0010);
        send(ADD, 4'b0100, 4'b0011);
        send(ADD, 4'b1010, 4'b1001);
        send(ADD, 4'b0110, 4'b1010);
        send(ADD, 4'b1101, 4'b0101);
        send(ADD, 4'b0101, 4'b0101);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        chk("bp_in_ready", bus0.in_ready, 0);
        chk("bp_accepts", n_acc, 2);
        repeat (2) @(posedge clk);
        #1;
        chk("bp_hold_valid", bus0.out_valid, 1);
        chk("bp_hold_sum", bus0.sum, 4'b0011);
        chk("bp_accepts_held", n_acc, 2);
        bus0.out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_total_accepts", n_acc, 6);

    // Reset with two operations in flight and acc = +5.
    push_exp(4'b0000, 0, 4'b0000, 0);
    send(CLR, 4'b0000, 4'b0000);
    push_exp(4'b0101, 0, 4'b0101, 0);
    send(ACC, 4'b0101, 4'b0000);
    drain();
    chk("pre_rst_acc", bus0.acc, 4'b0101);
    bus0.out_ready = 1'b0;
    send(ADD, 4'b0001, 4'b0010);
    send(ADD, 4'b0011, 4'b0011);
    chk("inflight_valid", bus0.out_valid, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_valid", bus0.out_valid, 0);
    chk("mid_rst_acc", bus0.acc, 0);
    chk("mid_rst_sum", bus0.sum, 0);
    bus0.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("no_stale_valid", bus0.out_valid, 0);
    push_exp(4'b0010, 0, 4'b0010, 0);
    send(ADD, 4'b0001, 4'b0001);
    drain();

    // Exhaustive ADD/SUB at full throughput; acc must stay at +3.
    push_exp(4'b0000, 0, 4'b0000, 0);
    send(CLR, 4'b0000, 4'b0000);
    push_exp(4'b0011, 0, 4'b0011, 0);
    send(ACC, 4'b0011, 4'b0000);
    drain();
    t0 = cyc;
    for (int o = 0; o < 2; o++) begin
      for (int i = 0; i < 16; i++) begin
        for (int j = 0; j < 16; j++) begin
          m0 = ref_model(2'(o), 4'(i), 4'(j), 1'b0);
          m1 = ref_model(2'(o), 4'(i), 4'(j), 1'b1);
          push_exp(m0[3:0], m0[4], m1[3:0], m1[4]);
          send(2'(o), 4'(i), 4'(j));
        end
      end
    end
    chk("throughput_cycles", cyc - t0, 512);
    drain();
    chk("acc_untouched", bus0.acc, 4'b0011);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
